divider_pipe: RTL and testbench

//  Parametrised, fully pipelined restoring integer divider; one new division per clock in steady state.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_step.sv | 43 ++++
 rtl/divider_pipe.sv | 143 ++++++++++++++
 tb/tb_divider_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module : divider_pkg
// Brief  : Shared control-flag type and stage-count helper for divider_pipe.
// Rev    : 1.0
// ============================================================================
package divider_pkg;

   // Per-operation control flags that travel alongside the datapath.
   typedef struct packed {
      logic valid;
      logic err;
      logic sign_q;
      logic sign_r;
   } div_ctrl_t;

   function automatic int div_stages(input int width, input int bps);
      return width / bps;
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Brief  : BITS_PER_STAGE chained restoring-division steps, purely combinational.
// Rev    : 1.0
// ============================================================================
module div_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_STAGE = 2
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] w_q;

   // w_q starts as the dividend: its MSB feeds the partial remainder while the
   // new quotient bit shifts in at the LSB, so after WIDTH steps it is the quotient.
   always_comb begin
      w_r     = i_rem;
      w_q     = i_quo;
      w_trial = '0;
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
         w_trial = {w_r, w_q[WIDTH-1]};
         w_q     = w_q << 1;
         if (w_trial >= {1'b0, i_divisor}) begin
            w_trial = w_trial - {1'b0, i_divisor};
            w_q[0]  = 1'b1;
         end
         w_r = w_trial[WIDTH-1:0];
      end
   end

   assign o_rem = w_r;
   assign o_quo = w_q;

endmodule
`default_nettype wire

// File: rtl/divider_pipe.sv
`default_nettype none
// ============================================================================
// Module : divider_pipe
// Brief  : Fully pipelined restoring divider, signed option, tag, valid/ready.
// Rev    : 1.0
// ============================================================================
module divider_pipe
   import divider_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_STAGE = 2,
   parameter int SIGNED         = 0,
   parameter int TAG_W          = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             data_valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             data_valid_out,
   input  logic             ready_in,
   output logic             error_out,
   output logic             busy_out
);

   localparam int   L        = div_stages(WIDTH, BITS_PER_STAGE);
   localparam logic C_SIGNED = (SIGNED != 0);

   typedef struct packed {
      div_ctrl_t        ctrl;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] rem;
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] divisor;
      logic [WIDTH-1:0] dividend_orig;
   } div_stage_t;

   if (WIDTH % BITS_PER_STAGE != 0) begin : g_bad_cfg
      $error("divider_pipe: WIDTH must be a multiple of BITS_PER_STAGE");
   end

   div_stage_t       r_stage    [L];
   div_stage_t       w_stage_in [L];
   div_stage_t       w_stage_nx [L];
   logic [WIDTH-1:0] w_rem_nx   [L];
   logic [WIDTH-1:0] w_quo_nx   [L];

   div_stage_t       w_head;
   div_stage_t       w_last;
   logic             w_stall;
   logic             w_accept;
   logic             w_sn;
   logic             w_sd;
   logic             w_zero;
   logic             w_busy;
   logic [WIDTH-1:0] w_n_abs;
   logic [WIDTH-1:0] w_d_abs;

   // One global enable: a stalled output freezes every stage, bubbles included.
   assign w_stall   = data_valid_out & ~ready_in;
   assign ready_out = ~w_stall;
   assign w_accept  = data_valid_in & ~w_stall;

   assign w_sn    = C_SIGNED & dividend_in[WIDTH-1];
   assign w_sd    = C_SIGNED & divisor_in[WIDTH-1];
   assign w_n_abs = w_sn ? -dividend_in : dividend_in;
   assign w_d_abs = w_sd ? -divisor_in  : divisor_in;
   assign w_zero  = (divisor_in == '0);

   always_comb begin
      w_head               = '0;
      w_head.ctrl.valid    = w_accept;
      w_head.ctrl.err      = w_zero;
      w_head.ctrl.sign_q   = w_sn ^ w_sd;
      w_head.ctrl.sign_r   = w_sn;
      w_head.tag           = tag_in;
      w_head.rem           = '0;
      w_head.quo           = w_n_abs;
      w_head.divisor       = w_d_abs;
      w_head.dividend_orig = dividend_in;
   end

   for (genvar k = 0; k < L; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign w_stage_in[k] = w_head;
      end else begin : g_next
         assign w_stage_in[k] = r_stage[k-1];
      end

      div_step #(
         .WIDTH          (WIDTH),
         .BITS_PER_STAGE (BITS_PER_STAGE)
      ) u_step (
         .i_rem     (w_stage_in[k].rem),
         .i_quo     (w_stage_in[k].quo),
         .i_divisor (w_stage_in[k].divisor),
         .o_rem     (w_rem_nx[k]),
         .o_quo     (w_quo_nx[k])
      );

      assign w_stage_nx[k] = {w_stage_in[k].ctrl, w_stage_in[k].tag, w_rem_nx[k],
                              w_quo_nx[k], w_stage_in[k].divisor,
                              w_stage_in[k].dividend_orig};
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < L; k++) begin
            r_stage[k] <= '0;
         end
      end else if (!w_stall) begin
         for (int k = 0; k < L; k++) begin
            r_stage[k] <= w_stage_nx[k];
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int k = 0; k < L; k++) begin
         w_busy = w_busy | r_stage[k].ctrl.valid;
      end
   end

   assign w_last = r_stage[L-1];

   // MIN / -1 needs no special case: magnitude 2^(WIDTH-1) negates back to MIN.
   assign data_valid_out = w_last.ctrl.valid;
   assign error_out      = w_last.ctrl.err;
   assign tag_out        = w_last.tag;
   assign busy_out       = w_busy;
   assign quotient_out   = w_last.ctrl.err    ? '1 :
                           w_last.ctrl.sign_q ? -w_last.quo : w_last.quo;
   assign remainder_out  = w_last.ctrl.err    ? w_last.dividend_orig :
                           w_last.ctrl.sign_r ? -w_last.rem : w_last.rem;

endmodule
`default_nettype wire

// File: tb/tb_divider_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_divider_pipe
// Brief  : Self-checking bench for divider_pipe (unsigned and signed instances).
// Rev    : 1.0
// ============================================================================
module tb_divider_pipe;

   localparam int L = 16;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
      logic [3:0]  t;
      int          acc;
   } exp_t;

   typedef struct {
      bit          sgn;
      logic [31:0] n;
      logic [31:0] d;
      logic [3:0]  t;
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Unsigned instance
   logic [31:0] u_dvd = '0, u_dvs = '0;
   logic [3:0]  u_tag = '0;
   logic        u_vin = 1'b0;
   logic        u_rdy_in = 1'b1;
   logic        u_rdy_out, u_dv_out, u_err, u_busy;
   logic [31:0] u_q, u_r;
   logic [3:0]  u_tout;

   // Signed instance
   logic [31:0] s_dvd = '0, s_dvs = '0;
   logic [3:0]  s_tag = '0;
   logic        s_vin = 1'b0;
   logic        s_rdy_in = 1'b1;
   logic        s_rdy_out, s_dv_out, s_err, s_busy;
   logic [31:0] s_q, s_r;
   logic [3:0]  s_tout;

   divider_pipe #(.WIDTH(32), .BITS_PER_STAGE(2), .SIGNED(0), .TAG_W(4)) u_dut (
      .clk_in(clk), .rst_in(rst), .dividend_in(u_dvd), .divisor_in(u_dvs),
      .tag_in(u_tag), .data_valid_in(u_vin), .ready_out(u_rdy_out),
      .quotient_out(u_q), .remainder_out(u_r), .tag_out(u_tout),
      .data_valid_out(u_dv_out), .ready_in(u_rdy_in), .error_out(u_err),
      .busy_out(u_busy));

   divider_pipe #(.WIDTH(32), .BITS_PER_STAGE(2), .SIGNED(1), .TAG_W(4)) s_dut (
      .clk_in(clk), .rst_in(rst), .dividend_in(s_dvd), .divisor_in(s_dvs),
      .tag_in(s_tag), .data_valid_in(s_vin), .ready_out(s_rdy_out),
      .quotient_out(s_q), .remainder_out(s_r), .tag_out(s_tout),
      .data_valid_out(s_dv_out), .ready_in(s_rdy_in), .error_out(s_err),
      .busy_out(s_busy));

   exp_t sb[$];
   bit   bp_mode   = 1'b0;
   bit   rdy_fixed = 1'b1;
   bit   lat_chk   = 1'b0;

   // Sole driver of the unsigned instance's ready_in.
   always @(posedge clk) begin
      #1;
      if (bp_mode) u_rdy_in = ($urandom_range(0, 99) < 30);
      else         u_rdy_in = rdy_fixed;
   end

   function automatic exp_t ref_div(input logic [31:0] n, input logic [31:0] d,
                                    input logic [3:0] t);
      exp_t x;
      x.t   = t;
      x.acc = 0;
      x.e   = (d == 32'd0);
      if (d == 32'd0) begin
         x.q = 32'hFFFF_FFFF;
         x.r = n;
      end else begin
         x.q = n / d;
         x.r = n % d;
      end
      return x;
   endfunction

   // Output monitor / scoreboard consumer for the unsigned instance.
   bit          stall_prev = 1'b0;
   logic [31:0] h_q, h_r;
   logic [3:0]  h_t;
   logic        h_e;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         checks++;
         if (u_rdy_out !== ~(u_dv_out & ~u_rdy_in)) begin
            failures++;
            $display("FAIL ready_out got=%b exp=%b", u_rdy_out, ~(u_dv_out & ~u_rdy_in));
         end
         if (stall_prev) begin
            checks++;
            if (u_dv_out !== 1'b1 || u_q !== h_q || u_r !== h_r || u_tout !== h_t || u_err !== h_e) begin
               failures++;
               $display("FAIL hold got v=%b q=%h r=%h t=%h e=%b exp v=1 q=%h r=%h t=%h e=%b",
                        u_dv_out, u_q, u_r, u_tout, u_err, h_q, h_r, h_t, h_e);
            end
         end else if (u_dv_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result got tag=%h q=%h exp none", u_tout, u_q);
            end else begin
               e = sb.pop_front();
               if (u_q !== e.q || u_r !== e.r || u_err !== e.e || u_tout !== e.t) begin
                  failures++;
                  $display("FAIL result got q=%h r=%h e=%b t=%h exp q=%h r=%h e=%b t=%h",
                           u_q, u_r, u_err, u_tout, e.q, e.r, e.e, e.t);
               end
               if (lat_chk) begin
                  checks++;
                  if (cyc - e.acc != L) begin
                     failures++;
                     $display("FAIL latency tag=%h got=%0d exp=%0d", e.t, cyc - e.acc, L);
                  end
               end
            end
         end
         stall_prev = u_dv_out & ~u_rdy_in;
         h_q = u_q; h_r = u_r; h_t = u_tout; h_e = u_err;
      end
   end

   // Hold operands until accepted, then queue the expectation.
   task automatic u_send(input logic [31:0] n, input logic [31:0] d, input logic [3:0] t,
                         input exp_t x);
      int   guard = 0;
      int   acyc  = 0;
      logic acc   = 1'b0;
      u_dvd = n; u_dvs = d; u_tag = t; u_vin = 1'b1;
      do begin
         @(negedge clk);
         acc  = u_rdy_out;
         acyc = cyc;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 2000);
      u_vin = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL accept_timeout tag=%h got=no_accept exp=accept", t);
      end else begin
         x.acc = acyc;
         sb.push_back(x);
      end
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || u_busy) && g < 3000) begin
         @(posedge clk);
         g++;
      end
      #1;
      checks++;
      if (sb.size() != 0 || u_busy) begin
         failures++;
         $display("FAIL drain got pending=%0d busy=%b exp pending=0 busy=0", sb.size(), u_busy);
      end
   endtask

   task automatic s_run(input vec_t v);
      int k = 0;
      s_dvd = v.n; s_dvs = v.d; s_tag = v.t; s_vin = 1'b1;
      @(negedge clk);
      checks++;
      if (s_rdy_out !== 1'b1) begin
         failures++;
         $display("FAIL s_ready got=%b exp=1", s_rdy_out);
      end
      @(posedge clk); #1;
      s_vin = 1'b0;
      do begin
         @(negedge clk);
         k++;
      end while (s_dv_out !== 1'b1 && k < 40);
      checks++;
      if (s_dv_out !== 1'b1 || k != L) begin
         failures++;
         $display("FAIL s_latency tag=%h got=%0d exp=%0d", v.t, k, L);
      end
      checks++;
      if (s_q !== v.q || s_r !== v.r || s_err !== v.e || s_tout !== v.t) begin
         failures++;
         $display("FAIL s_result got q=%h r=%h e=%b t=%h exp q=%h r=%h e=%b t=%h",
                  s_q, s_r, s_err, s_tout, v.q, v.r, v.e, v.t);
      end
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   vec_t vecs [10];

   initial begin
      exp_t x;
      logic [31:0] n, d;
      logic [3:0]  t;
      int          sel;

      vecs[0] = '{0, 32'd100,        32'd7,          4'h1, 32'd14,         32'd2,          1'b0};
      vecs[1] = '{0, 32'hFFFF_FFFF,  32'd1,          4'h2, 32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[2] = '{0, 32'd5,          32'd9,          4'h3, 32'd0,          32'd5,          1'b0};
      vecs[3] = '{0, 32'd42,         32'd0,          4'h4, 32'hFFFF_FFFF,  32'd42,         1'b1};
      vecs[4] = '{0, 32'd8,          32'd2,          4'h5, 32'd4,          32'd0,          1'b0};
      vecs[5] = '{1, 32'hFFFF_FFF9,  32'd2,          4'h6, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[6] = '{1, 32'd7,          32'hFFFF_FFFE,  4'h7, 32'hFFFF_FFFD,  32'd1,          1'b0};
      vecs[7] = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  4'h8, 32'h8000_0000,  32'd0,          1'b0};
      vecs[8] = '{1, 32'hFFFF_FFF9,  32'd0,          4'h9, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
      vecs[9] = '{1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  4'hA, 32'd2,          32'hFFFF_FFFE,  1'b0};

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", {31'd0, u_dv_out}, 32'd0);
      chk("rst_busy",  {31'd0, u_busy},   32'd0);
      chk("rst_err",   {31'd0, u_err},    32'd0);
      chk("rst_ready", {31'd0, u_rdy_out}, 32'd1);
      chk("rst_q",     u_q, 32'd0);
      chk("rst_r",     u_r, 32'd0);
      chk("rst_tag",   {28'd0, u_tout}, 32'd0);
      chk("rst_s_valid", {31'd0, s_dv_out}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #2;

      // Directed table: unsigned through scoreboard, signed directly
      lat_chk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!vecs[i].sgn) begin
            x = '{vecs[i].q, vecs[i].r, vecs[i].e, vecs[i].t, 0};
            u_send(vecs[i].n, vecs[i].d, vecs[i].t, x);
            drain();
         end else begin
            s_run(vecs[i]);
         end
      end

      // Back-to-back random stream, no stalls
      for (int i = 0; i < 1000; i++) begin
         sel = $urandom_range(0, 9);
         n   = $urandom;
         if (sel == 0)      d = 32'd0;
         else if (sel < 4)  d = $urandom_range(1, 255);
         else if (sel == 4) d = 32'h8000_0000 | $urandom;
         else               d = $urandom;
         t = 4'($urandom);
         u_send(n, d, t, ref_div(n, d, t));
      end
      drain();

      // Random backpressure, 30% ready duty
      lat_chk = 1'b0;
      bp_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         n = $urandom;
         d = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         t = 4'($urandom);
         u_send(n, d, t, ref_div(n, d, t));
      end
      drain();
      bp_mode = 1'b0;

      // Reset with a stalled result on the outputs and four more in flight
      rdy_fixed = 1'b0;
      @(posedge clk); #2;
      for (int i = 0; i < 5; i++) begin
         u_send(32'd1000 + i, 32'd3, 4'(i + 1), ref_div(32'd1000 + i, 32'd3, 4'(i + 1)));
      end
      repeat (18) @(posedge clk);
      #3 rst = 1'b1;
      sb.delete();
      #1;
      chk("arst_valid", {31'd0, u_dv_out}, 32'd0);
      chk("arst_busy",  {31'd0, u_busy},   32'd0);
      chk("arst_q",     u_q, 32'd0);
      chk("arst_tag",   {28'd0, u_tout}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      rdy_fixed = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      chk("post_rst_busy", {31'd0, u_busy}, 32'd0);
      lat_chk = 1'b1;
      u_send(32'd1000, 32'd10, 4'hC, '{32'd100, 32'd0, 1'b0, 4'hC, 0});
      drain();
      repeat (20) @(posedge clk);
      #1;
      chk("final_pending", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
